// File: rtl/lcd_bus_receiver.sv
// Responder for the 4-bit HD44780-style LCD write bus: reassembles bytes, models address counter and busy time.
// Optional LCD_SHADOW_EN adds a 32-cell shadow copy of the visible DDRAM window.
module lcd_bus_receiver #(
  parameter int BUSY_CYCLES = 2000,
  parameter int BUSY_LONG   = 82000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_w,
  input  logic       lcd_e,
  input  logic [3:0] data,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic       mode_4bit,
  output logic [6:0] ddram_addr,
  output logic       busy,
  output logic       protocol_err,
  input  logic [4:0] shadow_addr,
  output logic [7:0] shadow_data
);

  typedef enum logic [1:0] {MODE8, NIB_HI, NIB_LO} state_t;

  localparam logic [CNT_W-1:0] BUSY_N = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] BUSY_L = CNT_W'(BUSY_LONG);

  state_t           state_q, state_d;
  logic             lcd_e_q;
  logic             rs_q, w_q;
  logic [3:0]       data_q;
  logic [3:0]       hi_q, hi_d;
  logic             hi_rs_q, hi_rs_d;
  logic             byte_valid_q, byte_valid_d;
  logic [7:0]       byte_out_q, byte_out_d;
  logic             byte_rs_q, byte_rs_d;
  logic             mode_4bit_q, mode_4bit_d;
  logic [6:0]       addr_q, addr_d;
  logic             inc_q, inc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             strobe;

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      step_addr = 7'h40;
      else if (a == 7'h67) step_addr = 7'h00;
      else                 step_addr = a + 7'd1;
    end else begin
      if (a == 7'h00)      step_addr = 7'h67;
      else if (a == 7'h40) step_addr = 7'h27;
      else                 step_addr = a - 7'd1;
    end
  endfunction

  function automatic logic in_map(input logic [6:0] a);
    in_map = (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
  endfunction

  // Read strobes (w=1) are invisible to everything below.
  assign strobe = lcd_e_q & ~lcd_e & ~w_q;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    hi_rs_d      = hi_rs_q;
    byte_valid_d = 1'b0;
    byte_out_d   = byte_out_q;
    byte_rs_d    = byte_rs_q;
    mode_4bit_d  = mode_4bit_q;
    addr_d       = addr_q;
    inc_d        = inc_q;
    err_d        = err_q;
    cnt_d        = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

    if (strobe) begin
      if (cnt_q != '0) err_d = 1'b1;
      case (state_q)
        MODE8: begin
          byte_valid_d = 1'b1;
          byte_out_d   = {data_q, 4'b0000};
          byte_rs_d    = rs_q;
          if (data_q == 4'b0010) begin
            state_d     = NIB_HI;
            mode_4bit_d = 1'b1;
          end
        end
        NIB_HI: begin
          hi_d    = data_q;
          hi_rs_d = rs_q;
          state_d = NIB_LO;
        end
        default: begin
          state_d = NIB_HI;
          if (rs_q != hi_rs_q) begin
            err_d = 1'b1;
          end else begin
            byte_valid_d = 1'b1;
            byte_out_d   = {hi_q, data_q};
            byte_rs_d    = rs_q;
            if (!rs_q && hi_q == 4'b0011) begin
              state_d     = MODE8;
              mode_4bit_d = 1'b0;
            end
          end
        end
      endcase
    end

    // Command / data decode happens in the cycle byte_valid is high.
    if (byte_valid_q) begin
      cnt_d = BUSY_N;
      if (byte_rs_q) begin
        addr_d = step_addr(addr_q, inc_q);
      end else if (byte_out_q == 8'h01) begin
        addr_d = 7'h00;
        inc_d  = 1'b1;
        cnt_d  = BUSY_L;
      end else if (byte_out_q[7:1] == 7'b0000001) begin
        addr_d = 7'h00;
        cnt_d  = BUSY_L;
      end else if (byte_out_q[7:2] == 6'b000001) begin
        inc_d = byte_out_q[1];
      end else if (byte_out_q[7]) begin
        addr_d = byte_out_q[6:0];
        if (!in_map(byte_out_q[6:0])) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    rs_q   <= lcd_rs;
    w_q    <= lcd_w;
    data_q <= data;
    hi_q   <= hi_d;
    if (rst) begin
      state_q      <= MODE8;
      lcd_e_q      <= 1'b0;
      hi_rs_q      <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_out_q   <= 8'h00;
      byte_rs_q    <= 1'b0;
      mode_4bit_q  <= 1'b0;
      addr_q       <= 7'h00;
      inc_q        <= 1'b1;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lcd_e_q      <= lcd_e;
      hi_rs_q      <= hi_rs_d;
      byte_valid_q <= byte_valid_d;
      byte_out_q   <= byte_out_d;
      byte_rs_q    <= byte_rs_d;
      mode_4bit_q  <= mode_4bit_d;
      addr_q       <= addr_d;
      inc_q        <= inc_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_out     = byte_out_q;
  assign byte_rs      = byte_rs_q;
  assign mode_4bit    = mode_4bit_q;
  assign ddram_addr   = addr_q;
  assign busy         = (cnt_q != '0);
  assign protocol_err = err_q;

`ifdef LCD_SHADOW_EN
  logic [7:0] shadow_q [32];
  logic [4:0] fill_q, fill_d;
  logic       filling_q, filling_d;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic [7:0] wr_val;

  always_comb begin
    fill_d    = fill_q;
    filling_d = filling_q;
    wr_en     = 1'b0;
    wr_idx    = fill_q;
    wr_val    = 8'h20;
    if (filling_q) begin
      wr_en  = 1'b1;
      fill_d = fill_q + 5'd1;
      if (fill_q == 5'd31) filling_d = 1'b0;
    end
    if (byte_valid_q && !byte_rs_q && byte_out_q == 8'h01) begin
      filling_d = 1'b1;
      fill_d    = 5'd0;
    end else if (byte_valid_q && byte_rs_q &&
                 (addr_q[5:4] == 2'b00) && (addr_q[6] ? 1'b1 : 1'b1) && !addr_q[5] &&
                 ((addr_q[6:4] == 3'b000) || (addr_q[6:4] == 3'b100))) begin
      wr_en  = 1'b1;
      wr_idx = {addr_q[6], addr_q[3:0]};
      wr_val = byte_out_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= 8'h20;
      fill_q    <= 5'd0;
      filling_q <= 1'b0;
    end else begin
      if (wr_en) shadow_q[wr_idx] <= wr_val;
      fill_q    <= fill_d;
      filling_q <= filling_d;
    end
  end

  assign shadow_data = shadow_q[shadow_addr];
`else
  logic unused_shadow;
  assign unused_shadow = ^shadow_addr;
  assign shadow_data   = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with shortened busy times.
module tb_lcd_bus_receiver;
  localparam int BC = 20;
  localparam int BL = 100;

  logic       clk = 1'b0;
  logic       rst, lcd_rs, lcd_w, lcd_e;
  logic [3:0] data;
  logic       byte_valid, byte_rs, mode_4bit, busy, protocol_err;
  logic [7:0] byte_out, shadow_data;
  logic [6:0] ddram_addr;
  logic [4:0] shadow_addr;
  int checks = 0;
  int errors = 0;

  lcd_bus_receiver #(.BUSY_CYCLES(BC), .BUSY_LONG(BL), .CNT_W(17)) dut (
    .clk(clk), .rst(rst), .lcd_rs(lcd_rs), .lcd_w(lcd_w), .lcd_e(lcd_e), .data(data),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs), .mode_4bit(mode_4bit),
    .ddram_addr(ddram_addr), .busy(busy), .protocol_err(protocol_err),
    .shadow_addr(shadow_addr), .shadow_data(shadow_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left just after a rising edge; byte_valid is visible on return.
  task automatic strobe(input logic rs_i, input logic w_i, input logic [3:0] d);
    lcd_rs = rs_i; lcd_w = w_i; data = d; lcd_e = 1'b1;
    @(posedge clk); #1;
    lcd_e = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic rs_i, input logic [7:0] b);
    strobe(rs_i, 1'b0, b[7:4]);
    check("hi_nibble_no_pulse", 32'(byte_valid), 0);
    strobe(rs_i, 1'b0, b[3:0]);
    check("pair_pulse", 32'(byte_valid), 1);
    check("pair_byte", 32'(byte_out), 32'(b));
    check("pair_rs", 32'(byte_rs), 32'(rs_i));
  endtask

  task automatic wait_idle();
    int n;
    @(posedge clk); #1;
    n = 0;
    while (busy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_bv"}, 32'(byte_valid), 0);
    check({tag, "_byte"}, 32'(byte_out), 0);
    check({tag, "_rs"}, 32'(byte_rs), 0);
    check({tag, "_mode"}, 32'(mode_4bit), 0);
    check({tag, "_addr"}, 32'(ddram_addr), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(protocol_err), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_w = 1'b0; data = 4'h0; shadow_addr = 5'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // 8-bit init sequence
    strobe(1'b0, 1'b0, 4'h3);
    check("init1_bv", 32'(byte_valid), 1);
    check("init1_byte", 32'(byte_out), 'h30);
    check("init1_mode", 32'(mode_4bit), 0);
    wait_idle();
    strobe(1'b0, 1'b0, 4'h3);
    check("init2_byte", 32'(byte_out), 'h30);
    wait_idle();
    strobe(1'b0, 1'b0, 4'h2);
    check("init3_bv", 32'(byte_valid), 1);
    check("init3_byte", 32'(byte_out), 'h20);
    check("init3_mode", 32'(mode_4bit), 1);
    wait_idle();

    // 4-bit configuration
    send_byte(1'b0, 8'h28); wait_idle();
    check("mode_after_28", 32'(mode_4bit), 1);
    send_byte(1'b0, 8'h06); wait_idle();
    send_byte(1'b0, 8'h0C); wait_idle();
    send_byte(1'b0, 8'h01);
    @(posedge clk); #1;
    n = 0;
    while (busy && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("clear_busy_len", 32'(n), BL);
    send_byte(1'b0, 8'h80); wait_idle();
    check("cfg_addr", 32'(ddram_addr), 0);
    check("cfg_err", 32'(protocol_err), 0);

    // Data write with line wrap
    send_byte(1'b0, 8'hA7); wait_idle();
    check("set_addr_27", 32'(ddram_addr), 'h27);
    send_byte(1'b1, 8'h48); wait_idle();
    check("wrap_addr", 32'(ddram_addr), 'h40);
    shadow_addr = 5'd0; #1;
`ifdef LCD_SHADOW_EN
    check("shadow0_blank", 32'(shadow_data), 'h20);
`else
    check("shadow0_tied", 32'(shadow_data), 0);
`endif

    // Decrement mode
    send_byte(1'b0, 8'h04); wait_idle();
    send_byte(1'b0, 8'h80); wait_idle();
    send_byte(1'b1, 8'h41); wait_idle();
    check("dec_wrap_addr", 32'(ddram_addr), 'h67);
    send_byte(1'b1, 8'h42); wait_idle();
    check("dec_addr_66", 32'(ddram_addr), 'h66);
`ifdef LCD_SHADOW_EN
    check("shadow0_first", 32'(shadow_data), 'h41);
`else
    check("shadow0_tied2", 32'(shadow_data), 0);
`endif
    check("no_err_yet", 32'(protocol_err), 0);

    // rs mismatch between nibbles
    strobe(1'b1, 1'b0, 4'h4);
    check("mis_hi_bv", 32'(byte_valid), 0);
    strobe(1'b0, 1'b0, 4'h1);
    check("mis_lo_bv", 32'(byte_valid), 0);
    check("mis_err", 32'(protocol_err), 1);

    // Overrun while busy
    do_reset();
    check("rst_clears_err", 32'(protocol_err), 0);
    strobe(1'b0, 1'b0, 4'h3);
    check("ovr_first_bv", 32'(byte_valid), 1);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("ovr_busy", 32'(busy), 1);
    check("ovr_err_before", 32'(protocol_err), 0);
    strobe(1'b0, 1'b0, 4'h3);
    check("ovr_err", 32'(protocol_err), 1);
    check("ovr_still_decoded", 32'(byte_valid), 1);

    // Read strobes are ignored
    do_reset();
    strobe(1'b0, 1'b1, 4'h2);
    check("rd_bv", 32'(byte_valid), 0);
    check("rd_mode", 32'(mode_4bit), 0);
    check("rd_err", 32'(protocol_err), 0);
    @(posedge clk); #1;
    check("rd_busy", 32'(busy), 0);

    // Reset in the middle of a nibble pair
    strobe(1'b0, 1'b0, 4'h2);
    check("mid_enter4_bv", 32'(byte_valid), 1);
    check("mid_enter4_mode", 32'(mode_4bit), 1);
    wait_idle();
    strobe(1'b0, 1'b0, 4'h4);
    check("mid_hi_bv", 32'(byte_valid), 0);
    do_reset();
    check_reset_state("midrst");
    strobe(1'b0, 1'b0, 4'h3);
    check("after_rst_bv", 32'(byte_valid), 1);
    check("after_rst_byte", 32'(byte_out), 'h30);
    check("after_rst_mode", 32'(mode_4bit), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
